// File: rtl/accum_drain.sv
// Streams the accumulation buffer (addresses 0..row_out*col_out-1) out on a valid/ready port.
// Optional macro ACCUM_DRAIN_RELU_EN clamps sign-bit-set words to zero as they enter the output FIFO.
module accum_drain #(
  parameter int DataWidth   = 32,
  parameter int AddrWidth   = 18,
  parameter int MaxRowWidth = 9,
  parameter int MaxColWidth = 9
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   start,
  input  logic [MaxRowWidth-1:0] row_out,
  input  logic [MaxColWidth-1:0] col_out,
  output logic                   rd_en,
  output logic [AddrWidth-1:0]   rd_addr,
  input  logic [DataWidth-1:0]   rd_data,
  output logic [DataWidth-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int ProdWidth = MaxRowWidth + MaxColWidth;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [AddrWidth-1:0] total_q, total_d;
  logic [AddrWidth-1:0] rd_cnt_q, rd_cnt_d;
  logic [AddrWidth-1:0] beat_cnt_q, beat_cnt_d;
  logic                 inflight_q, inflight_d;
  logic [1:0]           fifo_cnt_q, fifo_cnt_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [DataWidth-1:0] fifo_mem_q [2];
  logic [DataWidth-1:0] fifo_wr_data_d;

  logic [ProdWidth-1:0] row_ext;
  logic [ProdWidth-1:0] col_ext;
  logic [AddrWidth-1:0] total_m1;
  logic                 pop;
  logic                 last_rd;
  logic                 last_beat;
  logic                 room;

  function automatic logic [DataWidth-1:0] relu_word(input logic [DataWidth-1:0] w);
`ifdef ACCUM_DRAIN_RELU_EN
    return w[DataWidth-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  assign row_ext   = {{MaxColWidth{1'b0}}, row_out};
  assign col_ext   = {{MaxRowWidth{1'b0}}, col_out};
  assign total_m1  = total_q - {{(AddrWidth-1){1'b0}}, 1'b1};
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign last_rd   = (rd_cnt_q == total_m1);
  assign last_beat = (beat_cnt_q == total_m1);
  // Slots already claimed (stored + landing next cycle) minus the one leaving now.
  assign room      = (({1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);

  assign rd_en    = (state_q == StRead) && (rd_cnt_q != total_q) && room;
  assign rd_addr  = rd_cnt_q;
  assign out_data = out_valid ? fifo_mem_q[rd_ptr_q] : '0;
  assign out_last = out_valid && last_beat;
  assign busy     = (state_q == StRead) || (state_q == StFlush);
  assign done     = (state_q == StDone);

  always_comb begin
    state_d        = state_q;
    total_d        = total_q;
    rd_cnt_d       = rd_cnt_q;
    beat_cnt_d     = beat_cnt_q;
    inflight_d     = rd_en;
    fifo_cnt_d     = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    wr_ptr_d       = wr_ptr_q ^ inflight_q;
    rd_ptr_d       = rd_ptr_q ^ pop;
    fifo_wr_data_d = relu_word(rd_data);

    if (rd_en) rd_cnt_d = rd_cnt_q + {{(AddrWidth-1){1'b0}}, 1'b1};
    if (pop)   beat_cnt_d = beat_cnt_q + {{(AddrWidth-1){1'b0}}, 1'b1};

    case (state_q)
      StIdle: begin
        if (start) begin
          total_d    = AddrWidth'(row_ext * col_ext);
          rd_cnt_d   = '0;
          beat_cnt_d = '0;
          state_d    = StRead;
        end
      end
      StRead: begin
        // An empty layer spends its single busy cycle here and finishes without reads.
        if (total_q == '0)        state_d = StDone;
        else if (rd_en && last_rd) state_d = StFlush;
      end
      StFlush: begin
        if (pop && last_beat) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= StIdle;
      total_q    <= '0;
      rd_cnt_q   <= '0;
      beat_cnt_q <= '0;
      inflight_q <= 1'b0;
      fifo_cnt_q <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      rd_cnt_q   <= rd_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage carries data only; validity lives in fifo_cnt_q, so no reset here.
  always_ff @(posedge Clk) begin
    if (inflight_q) fifo_mem_q[wr_ptr_q] <= fifo_wr_data_d;
  end

endmodule

// File: tb/tb_accum_drain.sv
// Directed bench for accum_drain: buffer model, expected-word queue and per-cycle output compare.
module tb_accum_drain;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        start;
  logic [8:0]  row_out;
  logic [8:0]  col_out;
  logic        rd_en;
  logic [17:0] rd_addr;
  logic [31:0] rd_data = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  accum_drain dut (
    .Clk(Clk), .Rst(Rst), .start(start), .row_out(row_out), .col_out(col_out),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  int ecount   = 0;

  logic [31:0] bufm  [0:31];
  logic [31:0] exp_w [0:31];
  int exp_n, beat_idx, issued, done_cnt, done_e, first_beat_e, last_beat_e, e0;
  logic [31:0] first_data, last_data;
  bit mon_en = 1'b0;

  always @(posedge Clk) ecount <= ecount + 1;
  always @(posedge Clk) if (rd_en) rd_data <= bufm[rd_addr[4:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] w);
`ifdef ACCUM_DRAIN_RELU_EN
    return w[31] ? 32'h0 : w;
`else
    return w;
`endif
  endfunction

  task automatic arm(input int n);
    exp_n = n;
    for (int i = 0; i < n; i++) exp_w[i] = model_word(bufm[i]);
    beat_idx = 0; issued = 0; done_cnt = 0; done_e = -1;
    first_beat_e = -1; last_beat_e = -1; first_data = 'x; last_data = 'x;
  endtask

  // Output compare against the expected-word queue, every cycle.
  always @(negedge Clk) begin
    if (mon_en && !Rst) begin
      if (out_valid) begin
        if (beat_idx >= exp_n) check("extra_beat", {31'b0, out_valid}, 32'h0);
        else begin
          check("out_data", out_data, exp_w[beat_idx]);
          check("out_last", {31'b0, out_last}, {31'b0, (beat_idx == exp_n - 1)});
        end
        if (out_ready) begin
          if (beat_idx == 0) begin first_beat_e = ecount; first_data = out_data; end
          last_beat_e = ecount; last_data = out_data;
          beat_idx++;
        end
      end else if (out_last) check("last_without_valid", {31'b0, out_last}, 32'h0);
      if (rd_en) begin
        check("rd_addr_order", {14'b0, rd_addr}, issued);
        issued++;
        if (issued > exp_n) check("extra_read", issued, exp_n);
      end
      if ((issued - beat_idx) > 2) check("outstanding_le2", issued - beat_idx, 2);
      if (done) begin
        done_cnt++; done_e = ecount;
        check("busy_low_at_done", {31'b0, busy}, 32'h0);
      end
    end
  end

  task automatic do_start(input int r, input int c, input bit expect_busy);
    @(posedge Clk); #1;
    start = 1'b1; row_out = 9'(r); col_out = 9'(c);
    @(posedge Clk); #1;
    e0 = ecount;
    start = 1'b0; row_out = 9'd7; col_out = 9'd7;
    @(negedge Clk);
    check("busy_after_start", {31'b0, busy}, {31'b0, expect_busy});
  endtask

  task automatic wait_done(input int maxc, input bit toggle);
    int k;
    k = 0;
    while (done_cnt == 0 && k < maxc) begin
      @(posedge Clk); #1;
      if (toggle) out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      k++;
    end
    check("done_seen", {31'b0, (done_cnt > 0)}, 32'h1);
    out_ready = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic load_floats();
    bufm[0] = 32'h3F800000; bufm[1] = 32'h40000000; bufm[2] = 32'h40400000;
    bufm[3] = 32'h40800000; bufm[4] = 32'h40A00000; bufm[5] = 32'h40C00000;
    bufm[6] = 32'h40E00000; bufm[7] = 32'h41000000; bufm[8] = 32'h41100000;
    for (int i = 9; i < 32; i++) bufm[i] = 32'h41200000 + (i << 16);
  endtask

  initial begin
    Rst = 1'b1; start = 1'b0; row_out = '0; col_out = '0; out_ready = 1'b1;
    load_floats();
    #3;
    check("rst_rd_en", {31'b0, rd_en}, 0);
    check("rst_rd_addr", {14'b0, rd_addr}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_last", {31'b0, out_last}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    mon_en = 1'b1;

    // 3x3, ready held high
    arm(9);
    do_start(3, 3, 1'b1);
    wait_done(60, 1'b0);
    check("3x3_beats", beat_idx, 9);
    check("3x3_done_cnt", done_cnt, 1);
    check("3x3_first_beat_cycle", first_beat_e, e0 + 2);
    check("3x3_last_beat_cycle", last_beat_e, e0 + 10);
    check("3x3_done_cycle", done_e, e0 + 11);
    check("3x3_first_word", first_data, 32'h3F800000);
    check("3x3_last_word", last_data, 32'h41100000);

    // 3x3, ready 1,0,0,1 repeating
    arm(9);
    do_start(3, 3, 1'b1);
    wait_done(120, 1'b1);
    check("stall_beats", beat_idx, 9);
    check("stall_reads", issued, 9);
    check("stall_done_cnt", done_cnt, 1);

    // empty layer
    arm(0);
    do_start(0, 5, 1'b1);
    wait_done(20, 1'b0);
    check("zero_reads", issued, 0);
    check("zero_beats", beat_idx, 0);
    check("zero_done_cycle", done_e, e0 + 1);
    check("zero_done_cnt", done_cnt, 1);

    // sign-bit words, 1x4
    bufm[0] = 32'hC0200000; bufm[1] = 32'h40400000; bufm[2] = 32'h80000000; bufm[3] = 32'h0;
    arm(4);
    do_start(1, 4, 1'b1);
    wait_done(40, 1'b0);
    check("relu_beats", beat_idx, 4);
`ifdef ACCUM_DRAIN_RELU_EN
    check("relu_first_word", first_data, 32'h0);
`else
    check("relu_first_word", first_data, 32'hC0200000);
`endif
    check("relu_last_word", last_data, 32'h0);

    // reset mid-drain after beat 4 of 4x4
    load_floats();
    arm(16);
    do_start(4, 4, 1'b1);
    for (int k = 0; k < 100 && beat_idx < 4; k++) begin
      @(posedge Clk); #1;
    end
    check("pre_reset_beats", {31'b0, (beat_idx >= 4)}, 32'h1);
    mon_en = 1'b0;
    Rst = 1'b1;
    #1;
    check("mid_rst_rd_en", {31'b0, rd_en}, 0);
    check("mid_rst_rd_addr", {14'b0, rd_addr}, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_valid", {31'b0, out_valid}, 0);
    check("mid_rst_out_last", {31'b0, out_last}, 0);
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_done", {31'b0, done}, 0);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      check("post_rst_idle", {29'b0, done, out_valid, busy}, 0);
    end
    arm(16);
    mon_en = 1'b1;
    do_start(4, 4, 1'b1);
    wait_done(80, 1'b0);
    check("redrain_beats", beat_idx, 16);
    check("redrain_first_word", first_data, 32'h3F800000);
    check("redrain_done_cnt", done_cnt, 1);

    // second start mid-drain is ignored
    arm(9);
    do_start(3, 3, 1'b1);
    repeat (3) @(posedge Clk);
    #1 start = 1'b1; row_out = 9'd2; col_out = 9'd2;
    @(posedge Clk);
    #1 start = 1'b0;
    wait_done(60, 1'b0);
    check("midstart_beats", beat_idx, 9);
    check("midstart_done_cnt", done_cnt, 1);
    check("midstart_done_cycle", done_e, e0 + 11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
